booth_mul_seq: RTL

- Multi-cycle signed radix-2 Booth multiplier for the ALU MUL path; the counterpart of the restoring divider.
- Computes the full 2*WIDTH-bit signed product of two WIDTH-bit operands at one Booth step per clock.
- The result is split into HI/LO words for the CPU's HI and LO registers.
- Start/busy/done handshake toward the control unit.

---
 rtl/mul_div_pkg.sv | 19 +
 rtl/booth_step.sv | 39 +++
 rtl/booth_mul_seq.sv | 131 +++++++++++++
 3 files changed

// File: rtl/mul_div_pkg.sv
// Shared definitions for the sequential multiply/divide datapaths.
//   WIDTH_DEFAULT / CNT_W_DEFAULT : default operand width and counter width
//   state_t                       : IDLE / RUN / DONE control states
//   BOOTH_ADD / BOOTH_SUB         : {Q[0], q_m1} pairs that trigger add / subtract
package mul_div_pkg;

    localparam int WIDTH_DEFAULT = 32;
    localparam int CNT_W_DEFAULT = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] BOOTH_ADD = 2'b01;
    localparam logic [1:0] BOOTH_SUB = 2'b10;

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth step: conditional add/subtract of the sign-extended
// multiplicand into the accumulator, then arithmetic shift of {A, Q, q_m1}.
//   a, q, q_m1, m              : current accumulator, multiplier, guard bit, multiplicand
//   a_next, q_next, q_m1_next  : register values after the step
module booth_step
    import mul_div_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic [WIDTH:0]   a,
    input  logic [WIDTH-1:0] q,
    input  logic             q_m1,
    input  logic [WIDTH-1:0] m,
    output logic [WIDTH:0]   a_next,
    output logic [WIDTH-1:0] q_next,
    output logic             q_m1_next
);

    logic [WIDTH:0] m_ext;
    logic [WIDTH:0] sum;

    // One extra accumulator bit keeps A - (-2^(WIDTH-1)) representable.
    assign m_ext = {m[WIDTH-1], m};

    always_comb begin
        sum = a;
        case ({q[0], q_m1})
            BOOTH_ADD: sum = a + m_ext;
            BOOTH_SUB: sum = a - m_ext;
            default:   sum = a;
        endcase
    end

    // Arithmetic right shift of the concatenation {sum, q, q_m1}.
    assign a_next    = {sum[WIDTH], sum[WIDTH:1]};
    assign q_next    = {sum[0], q[WIDTH-1:1]};
    assign q_m1_next = q[0];

endmodule

// File: rtl/booth_mul_seq.sv
// Sequential signed radix-2 Booth multiplier, one Booth step per clock.
//   clock, reset_n             : rising-edge clock, asynchronous active-low reset
//   start                      : request, accepted only while busy is low
//   multiplicand, multiplier   : signed operands, sampled at the accepting edge
//   busy                       : high while an operation is in flight (RUN or DONE)
//   done                       : one-cycle pulse, product_hi/product_lo valid
//   product_hi, product_lo     : upper / lower halves of the 2*WIDTH-bit product
//
// Handshake: a request is taken on a rising edge where start=1 and busy=0;
// while busy=1 start is ignored. Exactly WIDTH edges later done rises for one
// cycle, then busy drops on the following edge. The product outputs keep the
// previous result until the edge that raises done.
module booth_mul_seq
    import mul_div_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic [WIDTH-1:0] multiplier,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product_hi,
    output logic [WIDTH-1:0] product_lo
);

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    state_t state_q;
    state_t state_d;

    logic [WIDTH:0]   a_q;
    logic [WIDTH-1:0] q_q;
    logic             q_m1_q;
    logic [WIDTH-1:0] m_q;
    logic [CNT_W-1:0] count_q;

    logic [WIDTH:0]   a_n;
    logic [WIDTH-1:0] q_n;
    logic             q_m1_n;

    logic load;
    logic step_en;
    logic last_step;

    booth_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .a         (a_q),
        .q         (q_q),
        .q_m1      (q_m1_q),
        .m         (m_q),
        .a_next    (a_n),
        .q_next    (q_n),
        .q_m1_next (q_m1_n)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        load      = 1'b0;
        step_en   = 1'b0;
        last_step = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                step_en = 1'b1;
                // count holds the number of steps already taken
                if (count_q == LAST_STEP) begin
                    last_step = 1'b1;
                    state_d   = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            a_q        <= '0;
            q_q        <= '0;
            q_m1_q     <= 1'b0;
            m_q        <= '0;
            count_q    <= '0;
            product_hi <= '0;
            product_lo <= '0;
        end else begin
            if (load) begin
                a_q     <= '0;
                q_q     <= multiplier;
                q_m1_q  <= 1'b0;
                m_q     <= multiplicand;
                count_q <= '0;
            end else if (step_en) begin
                a_q     <= a_n;
                q_q     <= q_n;
                q_m1_q  <= q_m1_n;
                count_q <= count_q + CNT_W'(1);
            end
            // Low 2*WIDTH bits of the shifted {A, Q} form the product.
            if (last_step) begin
                product_hi <= a_n[WIDTH-1:0];
                product_lo <= q_n;
            end
        end
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);

endmodule
